log_dumper: RTL and testbench

Downstream readout stage for the MEMLog capture buffer. Once MEMLog signals full, a start pulse makes log_dumper assert the read request. It then sweeps every log address, fetches each packed 2×BRAM_DATA_WIDTH word, and serializes it as bytes over a valid/ready stream toward the host link (UART/GPIO bridge). It holds no log storage of its own, only one word under transmission.

---
 rtl/memlog_pkg.sv | 32 +++
 rtl/log_dumper_if.sv | 36 +++
 rtl/log_dumper_ser.sv | 58 +++++
 rtl/log_dumper.sv | 113 +++++++++++
 tb/tb_log_dumper.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memlog_pkg.sv
// rtl/memlog_pkg.sv - shared FSM encoding and word/byte geometry for the MEMLog readout path
// Contents:
//   state_t and IDLE..DONE  - log_dumper sequencer state encoding
//   bytes_per_word()        - bytes in one packed 2*BRAM_DATA_WIDTH word
//   byte_idx_width()        - width of a byte index within that word
//   BYTES_PER_WORD / BYTE_IDX_W evaluated for the default sample width
package memlog_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t ARM  = 3'd1;
  localparam state_t WAIT = 3'd2;
  localparam state_t LOAD = 3'd3;
  localparam state_t SEND = 3'd4;
  localparam state_t DONE = 3'd5;

  localparam int BRAM_DATA_WIDTH_DEF = 16;

  function automatic int bytes_per_word(input int data_width);
    return (2 * data_width) / 8;
  endfunction

  // A one-byte word still needs a 1-bit index so the serializer can be built.
  function automatic int byte_idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(BRAM_DATA_WIDTH_DEF);
  localparam int BYTE_IDX_W     = byte_idx_width(BYTES_PER_WORD);

endpackage

// File: rtl/log_dumper_if.sv
// rtl/log_dumper_if.sv - control, MEMLog read and byte-stream bundle of log_dumper
// Signals:
//   i_dump_start, i_dump_abort, i_mem_full          - control into the dumper
//   o_read_log, o_addr_log_to_mem, i_data_log_from_mem - MEMLog read port
//   o_byte, o_byte_valid, i_byte_ready              - byte stream toward the host link
//   o_busy, o_done, o_err_not_full                  - status
// Modports: master = log_dumper side, slave = environment side.
interface log_dumper_if #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
);

  logic                         i_dump_start;
  logic                         i_dump_abort;
  logic                         i_mem_full;
  logic                         o_read_log;
  logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem;
  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem;
  logic [7:0]                   o_byte;
  logic                         o_byte_valid;
  logic                         i_byte_ready;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_err_not_full;

  modport master (
    input  i_dump_start, i_dump_abort, i_mem_full, i_data_log_from_mem, i_byte_ready,
    output o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid, o_busy, o_done, o_err_not_full
  );

  modport slave (
    output i_dump_start, i_dump_abort, i_mem_full, i_data_log_from_mem, i_byte_ready,
    input  o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid, o_busy, o_done, o_err_not_full
  );

endinterface

// File: rtl/log_dumper_ser.sv
// rtl/log_dumper_ser.sv - word_to_byte_ser: shifts one captured word out as little-endian bytes
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clear           - drop the word in flight (abort)
//   load, word      - capture a new word, byte index restarts at 0
//   tdata/tvalid    - current byte (registered) and its valid
//   tready          - sink accepts the byte on tvalid && tready
//   tlast           - current byte is the last one of the word
module word_to_byte_ser
  import memlog_pkg::*;
#(
  parameter int WORD_W = 2 * BRAM_DATA_WIDTH_DEF,
  parameter int BPW    = BYTES_PER_WORD,
  parameter int IDX_W  = BYTE_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              valid_q;

  // The word is shifted right after each accepted byte, so the low byte of the
  // register is always the byte on offer and tdata comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      idx     <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && tready) begin
      shreg <= shreg >> 8;
      idx   <= idx + 1'b1;
      if (idx == LAST_IDX) valid_q <= 1'b0;
    end
  end

  assign tdata  = shreg[7:0];
  assign tvalid = valid_q;
  assign tlast  = (idx == LAST_IDX);

endmodule

// File: rtl/log_dumper.sv
// rtl/log_dumper.sv - MEMLog readout sequencer: sweeps every log address and streams it as bytes
// Ports:
//   clk   - system clock, rising edge
//   i_rst - asynchronous active-low reset
//   bus   - log_dumper_if.master: start/abort/full control, MEMLog read request,
//           address and data, byte stream, busy/done/not-full status
module log_dumper
  import memlog_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DEF
) (
  input logic          clk,
  input logic          i_rst,
  log_dumper_if.master bus
);

  localparam int WORD_W = 2 * BRAM_DATA_WIDTH;
  localparam int BPW    = bytes_per_word(BRAM_DATA_WIDTH);
  localparam int IDX_W  = byte_idx_width(BPW);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       read_log_q, read_log_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       ser_load, ser_clear, ser_valid, ser_last, xfer;
  logic [7:0]                 ser_byte;

  assign xfer = ser_valid && bus.i_byte_ready;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && bus.i_dump_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.i_dump_start && bus.i_mem_full) state_d = ARM;
        ARM:     state_d = WAIT;
        WAIT:    state_d = LOAD;
        LOAD:    state_d = SEND;
        SEND:    if (xfer && ser_last) state_d = (addr_q == LAST_ADDR) ? DONE : WAIT;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so each flag is
  // valid during the cycle its state occupies without a combinational path.
  always_comb begin
    read_log_d = (state_d == ARM);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_q == IDLE) && bus.i_dump_start && !bus.i_mem_full;
    addr_d     = addr_q;
    if (state_d == ARM || state_d == IDLE || state_d == DONE) begin
      addr_d = '0;
    end else if (state_q == SEND && state_d == WAIT) begin
      addr_d = addr_q + 1'b1;
    end
    ser_load  = (state_q == LOAD) && (state_d == SEND);
    ser_clear = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q     <= '0;
      read_log_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      read_log_q <= read_log_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  word_to_byte_ser #(
    .WORD_W(WORD_W),
    .BPW   (BPW),
    .IDX_W (IDX_W)
  ) u_ser (
    .clk   (clk),
    .rst_n (i_rst),
    .clear (ser_clear),
    .load  (ser_load),
    .word  (bus.i_data_log_from_mem),
    .tdata (ser_byte),
    .tvalid(ser_valid),
    .tready(bus.i_byte_ready),
    .tlast (ser_last)
  );

  assign bus.o_read_log        = read_log_q;
  assign bus.o_addr_log_to_mem = addr_q;
  assign bus.o_byte            = ser_byte;
  assign bus.o_byte_valid      = ser_valid;
  assign bus.o_busy            = busy_q;
  assign bus.o_done            = done_q;
  assign bus.o_err_not_full    = err_q;

endmodule

// File: tb/tb_log_dumper.sv
// tb/tb_log_dumper.sv - scoreboard bench for log_dumper with a 16-word MEMLog model
module tb_log_dumper;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int NWORDS = 1 << AW;
  localparam int BPW    = 2 * DW / 8;
  localparam int NBYTES = NWORDS * BPW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  log_dumper_if #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) bus ();

  log_dumper #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ready_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         n_bytes, n_read, n_done, n_err, n_valid, done_cyc, start_cyc;
  logic [7:0] first_bytes[8];
  bit         hold_pending;
  logic [7:0] hold_byte;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    bus.i_byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.i_byte_ready = 1'b1;
        1:       bus.i_byte_ready = 1'($urandom_range(0, 1));
        default: bus.i_byte_ready = 1'b0;
      endcase
    end
  end

  // MEMLog model: word = A5C3_0000 | address, available the cycle after the address.
  initial begin
    bus.i_data_log_from_mem = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_data_log_from_mem = 32'hA5C30000 | 32'(bus.o_addr_log_to_mem);
    end
  end

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.o_read_log) n_read++;
    if (bus.o_done) begin n_done++; done_cyc = cyc; end
    if (bus.o_err_not_full) n_err++;
    if (bus.o_byte_valid) begin
      n_valid++;
      if (hold_pending) begin
        checks++;
        if (bus.o_byte !== hold_byte) begin
          errors++;
          $display("FAIL byte_stable: o_byte %02h changed from held %02h", bus.o_byte, hold_byte);
        end
      end
      if (bus.i_byte_ready) begin
        if (n_bytes < 8) first_bytes[n_bytes[2:0]] = bus.o_byte;
        n_bytes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got byte %02h, none expected", bus.o_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.o_byte !== exp_b) begin
            errors++;
            $display("FAIL sb_byte %0d: got %02h want %02h", n_bytes - 1, bus.o_byte, exp_b);
          end
        end
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        hold_byte    = bus.o_byte;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_counters();
    n_bytes = 0; n_read = 0; n_done = 0; n_err = 0; n_valid = 0;
    done_cyc = -1; hold_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_expected();
    logic [31:0] w;
    for (int a = 0; a < NWORDS; a++) begin
      w = 32'hA5C30000 | 32'(a);
      for (int b = 0; b < BPW; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.i_dump_start = 1'b1;
    @(posedge clk); #1;
    bus.i_dump_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (n_done > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_sweep(input int mode, input int budget, output bit ok);
    @(posedge clk); #1;
    clear_counters();
    bus.i_mem_full = 1'b1;
    ready_mode     = mode;
    push_expected();
    pulse_start();
    wait_done(budget, ok);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.i_dump_start = 1'($urandom_range(0, 1));
      bus.i_dump_abort = 1'($urandom_range(0, 1));
      bus.i_mem_full   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checks++; if (bus.o_read_log !== 1'b0)     begin errors++; $display("FAIL reset_read_log: got %b want 0", bus.o_read_log); end
    checks++; if (bus.o_byte_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_byte_valid); end
    checks++; if (bus.o_busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    checks++; if (bus.o_err_not_full !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.o_err_not_full); end
    checks++; if (bus.o_addr_log_to_mem !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.o_addr_log_to_mem); end
    checks++; if (bus.o_byte !== 8'h00)        begin errors++; $display("FAIL reset_byte: got %02h want 00", bus.o_byte); end
    @(posedge clk); #1;
    bus.i_dump_start = 1'b0; bus.i_dump_abort = 1'b0; bus.i_mem_full = 1'b0;
    ready_mode = 0;
    clear_counters();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0)       begin errors++; $display("FAIL release_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", bus.o_byte_valid); end
  endtask

  task automatic test_refused_start();
    @(posedge clk); #1;
    clear_counters();
    bus.i_mem_full = 1'b0;
    pulse_start();
    repeat (20) @(posedge clk);
    #2;
    checks++; if (n_err !== 1)   begin errors++; $display("FAIL refused_err_pulses: got %0d want 1", n_err); end
    checks++; if (n_read !== 0)  begin errors++; $display("FAIL refused_read_log: got %0d want 0", n_read); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL refused_valid_cycles: got %0d want 0", n_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL refused_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_full_sweep();
    bit ok;
    logic [7:0] exp_first[8];
    exp_first = '{8'h00, 8'h00, 8'hC3, 8'hA5, 8'h01, 8'h00, 8'hC3, 8'hA5};
    run_sweep(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sweep_timeout: o_done seen %0d want 1", n_done); end
    checks++; if (n_bytes !== NBYTES) begin errors++; $display("FAIL sweep_bytes: got %0d want %0d", n_bytes, NBYTES); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (first_bytes[i] !== exp_first[i]) begin
        errors++; $display("FAIL sweep_first_byte %0d: got %02h want %02h", i, first_bytes[i], exp_first[i]);
      end
    end
    checks++; if (n_read !== 1) begin errors++; $display("FAIL sweep_read_log: got %0d want 1", n_read); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL sweep_done_pulses: got %0d want 1", n_done); end
    checks++; if (done_cyc - start_cyc + 1 !== 98) begin errors++; $display("FAIL sweep_done_cycle: got %0d want 98", done_cyc - start_cyc + 1); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sweep_leftover: got %0d want 0", exp_q.size()); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_after: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    run_sweep(1, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: o_done seen %0d want 1", n_done); end
    checks++; if (n_bytes !== NBYTES) begin errors++; $display("FAIL bp_bytes: got %0d want %0d", n_bytes, NBYTES); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    checks++; if (n_read !== 1) begin errors++; $display("FAIL bp_read_log: got %0d want 1", n_read); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_abort();
    bit ok;
    bit hit;
    @(posedge clk); #1;
    clear_counters();
    bus.i_mem_full = 1'b1;
    ready_mode = 0;
    push_expected();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (n_bytes >= 21) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach: got %0d bytes want 21", n_bytes); end
    // Byte 1 of word 5 is accepted this cycle; byte 2 is then held by a stalled sink.
    ready_mode = 2;
    @(posedge clk); #2;
    bus.i_dump_abort = 1'b1;
    @(posedge clk); #2;
    bus.i_dump_abort = 1'b0;
    checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.o_byte_valid); end
    checks++; if (bus.o_busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b want 0", bus.o_busy); end
    repeat (10) @(posedge clk);
    #2;
    checks++; if (n_done !== 0)  begin errors++; $display("FAIL abort_done: got %0d want 0", n_done); end
    checks++; if (n_bytes !== 22) begin errors++; $display("FAIL abort_bytes: got %0d want 22", n_bytes); end
    checks++; if (exp_q.size() !== NBYTES - 22) begin errors++; $display("FAIL abort_leftover: got %0d want %0d", exp_q.size(), NBYTES - 22); end
    run_sweep(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: o_done seen %0d want 1", n_done); end
    checks++; if (n_bytes !== NBYTES) begin errors++; $display("FAIL restart_bytes: got %0d want %0d", n_bytes, NBYTES); end
    checks++; if (first_bytes[2] !== 8'hC3) begin errors++; $display("FAIL restart_byte2: got %02h want C3", first_bytes[2]); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL restart_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_busy_start_ignored();
    bit ok;
    @(posedge clk); #1;
    clear_counters();
    bus.i_mem_full = 1'b1;
    ready_mode = 0;
    push_expected();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      bus.i_dump_start = (i % 7 == 3);
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    bus.i_dump_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: o_done seen %0d want 1", n_done); end
    checks++; if (n_bytes !== NBYTES) begin errors++; $display("FAIL busy_bytes: got %0d want %0d", n_bytes, NBYTES); end
    checks++; if (n_read !== 1) begin errors++; $display("FAIL busy_read_log: got %0d want 1", n_read); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_done_pulses: got %0d want 1", n_done); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL busy_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_sweep();
    bit hit;
    @(posedge clk); #1;
    clear_counters();
    bus.i_mem_full = 1'b1;
    ready_mode = 0;
    push_expected();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (n_bytes >= 36) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_reach: got %0d bytes want 36", n_bytes); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_byte_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b want 0", bus.o_byte_valid); end
    checks++; if (bus.o_addr_log_to_mem !== '0) begin errors++; $display("FAIL rst_addr: got %0h want 0", bus.o_addr_log_to_mem); end
    checks++; if (bus.o_byte !== 8'h00)        begin errors++; $display("FAIL rst_byte: got %02h want 00", bus.o_byte); end
    checks++; if (bus.o_read_log !== 1'b0)     begin errors++; $display("FAIL rst_read_log: got %b want 0", bus.o_read_log); end
    checks++; if (bus.o_done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus.i_dump_start = 1'b0;
    bus.i_dump_abort = 1'b0;
    bus.i_mem_full   = 1'b0;
    test_reset();
    test_refused_start();
    test_full_sweep();
    test_backpressure();
    test_abort();
    test_busy_start_ignored();
    test_reset_mid_sweep();
    test_full_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
